dma_copy_engine: RTL and testbench
==================================

// Module: dma_copy_engine
// PURPOSE
//  Block-copy engine that acts as the initiator on the data-memory port (A/WD/WE/RD).
//  - Copies LEN consecutive words from word address SRC to word address DST.
//  - Sits beside the datapath and owns the data-memory port while busy.
//  - Two cycles per word: a combinational read, then a registered write.
// PARAMETERS
//  DATA_W    32   data word width (WD, RD)
//  ADDR_W    32   address width (A, src_addr, dst_addr); addresses are word indices
//  LEN_W     16   width of the transfer length
//  MEM_SIZE  100  words in the target memory; used for the range check
// PORTS
//  CLK         in   1       clock; all state changes on posedge
//  reset       in   1       asynchronous, active-low reset
//  start       in   1       request a transfer; sampled only in IDLE
//  src_addr    in   ADDR_W  first source word address
//  dst_addr    in   ADDR_W  first destination word address
//  len         in   LEN_W   number of words to transfer
//  A           out  ADDR_W  memory address
//  WD          out  DATA_W  memory write data
//  WE          out  1       memory write enable
//  RD          in   DATA_W  memory read data; combinational from A
//  busy        out  1       transfer in progress (RD_S or WR_S)
//  done        out  1       one-cycle pulse at the end of every accepted start
//  err         out  1       valid with done: range violation, nothing written
//  xfer_count  out  LEN_W   words written in the current/last transfer
// BEHAVIOUR
//  Reset (reset=0, async):
//  - state=IDLE; A=0, WD=0, WE=0, busy=0, done=0, err=0, xfer_count=0.
//  - Internal pointers, remaining count and data buffer are cleared.
//  FSM states: IDLE, RD_S, WR_S, DONE_S. Outputs are decoded from registered state/pointers.
//  - IDLE, start=1, len==0: go to DONE_S with err=0; no memory access.
//  - IDLE, start=1, range fail: go to DONE_S with err=1; no memory access.
//    Range fail means src_addr+len > MEM_SIZE or dst_addr+len > MEM_SIZE.
//    Compute the sums in ADDR_W+1 bits so they do not wrap.
//  - IDLE, start=1, otherwise: latch src/dst/len, clear xfer_count, go to RD_S.
//  - RD_S: A=src_ptr, WE=0. At the edge: buf<=RD, src_ptr++, go to WR_S.
//  - WR_S: A=dst_ptr, WD=buf, WE=1. At the edge: dst_ptr++, remaining--, xfer_count++.
//    Go to DONE_S if remaining was 1; otherwise go to RD_S.
//  - DONE_S: done=1 for exactly one cycle; busy=0; err is valid. Then go to IDLE.
//  - In IDLE and DONE_S: A=0, WE=0. err holds its value until the next start is accepted.
//  Timing: if start is sampled at edge t and len=N>0 is in range:
//  - busy is high for cycles t+1 .. t+2N.
//  - The last WE is in cycle t+2N; done pulses in cycle t+2N+1.
//  start while busy or in DONE_S: ignored, not queued.
//  Overlap: copy is strictly ascending, word by word.
//  - If dst > src and the regions overlap, already-written source words get re-read.
//  - That is the defined result; no hazard detection.
//  Reset mid-transfer: abort immediately and drop WE.
//  - Words already written remain in memory; no done pulse.
// CONFIGURATION
//  DMA_FILL_EN defined: adds ports fill_mode (in, 1) and fill_value (in, DATA_W).
//  - If fill_mode=1 at accepted start: latch fill_value and skip RD_S.
//  - WR_S repeats with WD=fill_value: one word per cycle, busy for N cycles.
//  - Only the dst range is checked.
//  DMA_FILL_EN undefined: these ports do not exist; every transfer is a copy.
// TESTING
//  1 Reset: hold reset=0 with CLK running -> all outputs 0, state IDLE; release -> still idle.
//  2 Copy, mem[10..13]=A,B,C,D, src=10 dst=50 len=4, start @t
//    -> WE in t+2,t+4,t+6,t+8 at A=50..53 with WD=A..D.
//    -> done@t+9 with err=0, xfer_count=4.
//  3 Boundaries:
//    -> len=0 -> done@t+1, err=0, WE never asserted.
//    -> src=98 len=4 -> done@t+1, err=1, WE never asserted.
//    -> dst=96 len=4 -> in range, completes normally.
//  4 start held high throughout the 4-word copy of test 2
//    -> exactly one transfer; a second one starts only on the start sampled in IDLE after done.
//  5 Reset asserted at cycle t+5 of test 2 -> WE low immediately, busy=0.
//    -> mem[50..51] written, mem[52..53] unchanged, no done pulse.
//  6 DMA_FILL_EN: fill_mode=1, fill_value=32'hDEADBEEF, dst=20 len=3
//    -> WE in t+1..t+3, mem[20..22]=DEADBEEF, done@t+4.

Source files
------------

// File: rtl/dma_copy_engine_if.sv
// Data-memory port driven by dma_copy_engine: address, write data/enable out,
// combinational read data back.
interface dma_copy_engine_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] WD;
  logic              WE;
  logic [DATA_W-1:0] RD;

  modport master (output A, output WD, output WE, input RD);
  modport slave  (input A, input WD, input WE, output RD);
endinterface

// File: rtl/dma_copy_engine.sv
// Block-copy engine owning the data-memory port while busy: read word, write word.
// Optional DMA_FILL_EN adds a fill mode that writes fill_value once per cycle.
module dma_copy_engine #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned MEM_SIZE = 100
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
`ifdef DMA_FILL_EN
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_value,
`endif
  dma_copy_engine_if.master mem,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  xfer_count
);

  typedef enum logic [1:0] {IDLE, RD_S, WR_S, DONE_S} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_rem;
  logic              r_fill;
  logic [ADDR_W-1:0] r_a;
  logic [DATA_W-1:0] r_wd;
  logic              r_we;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [LEN_W-1:0]  r_xfer;

  logic              w_fill_req;
  logic [DATA_W-1:0] w_fill_value;
  logic [ADDR_W:0]   w_src_end;
  logic [ADDR_W:0]   w_dst_end;
  logic [ADDR_W:0]   w_lim;
  logic              w_range_fail;

`ifdef DMA_FILL_EN
  assign w_fill_req   = fill_mode;
  assign w_fill_value = fill_value;
`else
  assign w_fill_req   = 1'b0;
  assign w_fill_value = '0;
`endif

  // One extra bit keeps address+length from wrapping past the limit.
  assign w_src_end    = {1'b0, src_addr} + (ADDR_W+1)'(len);
  assign w_dst_end    = {1'b0, dst_addr} + (ADDR_W+1)'(len);
  assign w_lim        = (ADDR_W+1)'(MEM_SIZE);
  assign w_range_fail = (!w_fill_req && (w_src_end > w_lim)) || (w_dst_end > w_lim);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_fill  <= 1'b0;
      r_a     <= '0;
      r_wd    <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_xfer  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_xfer <= '0;
            if (len == '0 || w_range_fail) begin
              // Zero length takes priority: never an error, even if addresses are out of range.
              r_err   <= (len != '0);
              r_done  <= 1'b1;
              r_state <= DONE_S;
            end else begin
              r_err  <= 1'b0;
              r_src  <= src_addr;
              r_dst  <= dst_addr;
              r_rem  <= len;
              r_fill <= w_fill_req;
              r_busy <= 1'b1;
              if (w_fill_req) begin
                r_wd    <= w_fill_value;
                r_a     <= dst_addr;
                r_we    <= 1'b1;
                r_state <= WR_S;
              end else begin
                r_a     <= src_addr;
                r_state <= RD_S;
              end
            end
          end
        end
        RD_S: begin
          r_wd    <= mem.RD;
          r_src   <= r_src + ADDR_W'(1);
          r_a     <= r_dst;
          r_we    <= 1'b1;
          r_state <= WR_S;
        end
        WR_S: begin
          r_dst  <= r_dst + ADDR_W'(1);
          r_rem  <= r_rem - LEN_W'(1);
          r_xfer <= r_xfer + LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            r_we    <= 1'b0;
            r_a     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE_S;
          end else if (r_fill) begin
            r_a <= r_dst + ADDR_W'(1);
          end else begin
            r_we    <= 1'b0;
            r_a     <= r_src;
            r_state <= RD_S;
          end
        end
        DONE_S: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem.A      = r_a;
  assign mem.WD     = r_wd;
  assign mem.WE     = r_we;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign xfer_count = r_xfer;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: directed and random transfers against a word-array
// reference model, with cycle-exact write/done timing.
module tb_dma_copy_engine;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int LEN_W    = 16;
  localparam int MEM_SIZE = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src = '0;
  logic [ADDR_W-1:0] dst = '0;
  logic [LEN_W-1:0]  len = '0;
`ifdef DMA_FILL_EN
  logic              fill_mode = 1'b0;
  logic [DATA_W-1:0] fill_value = '0;
`endif
  logic              busy;
  logic              done;
  logic              err;
  logic [LEN_W-1:0]  xfer;

  logic              pk_en = 1'b0;
  logic [6:0]        pk_addr = '0;
  logic [DATA_W-1:0] pk_data = '0;

  logic [DATA_W-1:0] mem  [MEM_SIZE];
  logic [DATA_W-1:0] refm [MEM_SIZE];

  int n_chk = 0;
  int n_err = 0;

  dma_copy_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dma_copy_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MEM_SIZE(MEM_SIZE)
  ) dut (
    .CLK        (clk),
    .reset      (rst_n),
    .start      (start),
    .src_addr   (src),
    .dst_addr   (dst),
    .len        (len),
`ifdef DMA_FILL_EN
    .fill_mode  (fill_mode),
    .fill_value (fill_value),
`endif
    .mem        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .xfer_count (xfer)
  );

  always #5 clk = ~clk;

  assign bus.RD = (bus.A < MEM_SIZE) ? mem[bus.A[6:0]] : '0;

  always @(posedge clk) begin
    if (pk_en) mem[pk_addr] <= pk_data;
    else if (bus.WE && bus.A < MEM_SIZE) mem[bus.A[6:0]] <= bus.WD;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int a, input logic [DATA_W-1:0] v);
    pk_en = 1'b1; pk_addr = a[6:0]; pk_data = v;
    tick();
    pk_en = 1'b0;
    refm[a] = v;
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== refm[i]) bad++;
    chk(tag, bad, 0);
  endtask

  // Model: a transfer writes dst+i with src+i (or the fill value) in ascending order.
  task automatic run_xfer(input int s, input int d, input int n, input bit f, input logic [DATA_W-1:0] fv);
    logic [DATA_W-1:0] exp_wd[$];
    int  exp_done, wi, done_k, busy_n;
    bit  e;
    logic err_at;
    logic [LEN_W-1:0] xf_at;
    e = (n != 0) && ((!f && (s + n > MEM_SIZE)) || (d + n > MEM_SIZE));
    if (n != 0 && !e)
      for (int i = 0; i < n; i++) begin
        logic [DATA_W-1:0] v;
        v = f ? fv : refm[s+i];
        exp_wd.push_back(v);
        refm[d+i] = v;
      end
    exp_done = (exp_wd.size() == 0) ? 1 : (f ? n + 1 : 2*n + 1);

    src = s; dst = d; len = n[LEN_W-1:0]; start = 1'b1;
`ifdef DMA_FILL_EN
    fill_mode = f; fill_value = fv;
`endif
    wi = 0; done_k = 0; busy_n = 0; err_at = 1'b0; xf_at = '0;
    for (int k = 1; k <= 2*n + 12 && done_k == 0; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (busy) busy_n++;
      if (bus.WE) begin
        if (wi < exp_wd.size()) begin
          chk("we_cycle", k, f ? wi + 1 : 2*wi + 2);
          chk("we_addr", bus.A, d + wi);
          chk("we_data", bus.WD, exp_wd[wi]);
        end else chk("we_extra", wi + 1, exp_wd.size());
        wi++;
      end
      if (done) begin done_k = k; err_at = err; xf_at = xfer; end
    end
    chk("done_cycle", done_k, exp_done);
    chk("we_count", wi, exp_wd.size());
    chk("busy_cycles", busy_n, (exp_wd.size() == 0) ? 0 : (f ? n : 2*n));
    if (done_k != 0) begin
      chk("err", err_at, e);
      if (exp_wd.size() != 0) chk("xfer_count", xf_at, n);
    end
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("err_hold", err, e);
    chk("idle_we", bus.WE, 1'b0);
    check_mem("mem_image");
  endtask

  initial begin
    int dn, wn, got;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, wn, got;
    // Reset held with clock running
    repeat (3) tick();
    chk("rst_A", bus.A, 0);
    chk("rst_WD", bus.WD, 0);
    chk("rst_WE", bus.WE, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_xfer", xfer, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_we", bus.WE, 0);
    chk("post_rst_done", done, 0);

    for (int i = 0; i < MEM_SIZE; i++) poke(i, $urandom);

    // Basic 4-word copy
    poke(10, 32'hAAAA_0001); poke(11, 32'hBBBB_0002);
    poke(12, 32'hCCCC_0003); poke(13, 32'hDDDD_0004);
    run_xfer(10, 50, 4, 1'b0, '0);

    // Boundaries
    run_xfer(5, 5, 0, 1'b0, '0);
    run_xfer(98, 10, 4, 1'b0, '0);
    run_xfer(0, 96, 4, 1'b0, '0);
    run_xfer(20, 22, 5, 1'b0, '0);

    // start held high across a whole transfer
    for (int i = 0; i < 4; i++) refm[50+i] = refm[10+i];
    src = 10; dst = 50; len = 4; start = 1'b1;
    dn = 0; wn = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (done) dn++;
      if (k <= 9 && bus.WE) wn++;
      if (k == 10) chk("held_idle_busy", busy, 0);
      if (k == 11) chk("held_restart_busy", busy, 1);
    end
    chk("held_done_count", dn, 1);
    chk("held_we_count", wn, 4);
    start = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      tick();
      if (done) got = 1;
    end
    chk("held_second_done", got, 1);
    tick();
    check_mem("held_mem");

    // Reset during the third word's read
    for (int i = 0; i < 4; i++) poke(50 + i, 32'h5A5A_0000 + i);
    refm[50] = refm[10];
    refm[51] = refm[11];
    src = 10; dst = 50; len = 4; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_we", bus.WE, 0);
    chk("abort_busy", busy, 0);
    dn = 0;
    repeat (3) begin tick(); if (done) dn++; end
    rst_n = 1'b1;
    repeat (4) begin tick(); if (done) dn++; end
    chk("abort_no_done", dn, 0);
    check_mem("abort_mem");

`ifdef DMA_FILL_EN
    run_xfer(0, 20, 3, 1'b1, 32'hDEAD_BEEF);
    run_xfer(200, 97, 3, 1'b1, 32'h1234_5678);
`endif

    // Random transfers
    for (int t = 0; t < 24; t++) begin
      int s, d, n;
      bit f;
      n = $urandom_range(0, 8);
      s = $urandom_range(0, 99);
      d = $urandom_range(0, 99);
      f = 1'b0;
`ifdef DMA_FILL_EN
      f = $urandom_range(0, 1);
`endif
      run_xfer(s, d, n, f, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
